voice_scheduler: RTL and testbench

- Sequencing controller between the MIDI event stream and the oscillator bank.
- Accepts note-on/note-off events over a valid/ready handshake and scans voice state one voice per cycle.
- Picks a voice by retrigger, then free, then least-recently-allocated, and issues a single registered config write to the bank.
- Owns the per-voice on/rate/age tables and exports the active-voice bitmap to the mixer.

---
 rtl/voice_scheduler.sv | 163 ++++++++++++++++
 tb/tb_voice_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Voice allocator: scans per-voice state one voice per cycle, then commits a single bank config write.
// Build option VOICE_STEAL_EN: when defined, a note-on with no match and no free voice steals the oldest voice.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int RATE_WIDTH = 24,
    parameter int AGE_WIDTH  = 16,
    localparam int IDX_W     = $clog2(NUM_VOICES)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  event_valid_in,
    output logic                  event_ready_out,
    input  logic                  event_is_on_in,
    input  logic [RATE_WIDTH-1:0] event_rate_in,
    output logic                  cfg_valid_out,
    output logic [IDX_W-1:0]      cfg_voice_out,
    output logic                  cfg_on_out,
    output logic [RATE_WIDTH-1:0] cfg_rate_out,
    output logic [NUM_VOICES-1:0] voice_on_out,
    output logic                  steal_out,
    output logic                  drop_out
);
    // state  | meaning
    // IDLE   | ready; waiting for an event
    // SCAN   | examining voice[idx], one voice per cycle
    // COMMIT | applying the decision and registering outputs
    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic                  is_on_q;
    logic [RATE_WIDTH-1:0] rate_q;

    logic [NUM_VOICES-1:0] on_tbl;
    logic [RATE_WIDTH-1:0] rate_tbl [NUM_VOICES];
    logic [AGE_WIDTH-1:0]  age_tbl  [NUM_VOICES];

    logic                  match_found, free_found, old_found;
    logic [IDX_W-1:0]      match_idx, free_idx, old_idx;
    logic [AGE_WIDTH-1:0]  old_age;

    logic                  write_on, write_off, do_steal;
    logic [IDX_W-1:0]      tgt;

    assign event_ready_out = (state == IDLE) & rst_in;
    assign voice_on_out    = on_tbl;

    always_comb begin
        tgt       = old_idx;
        write_on  = 1'b0;
        write_off = 1'b0;
        do_steal  = 1'b0;
        if (is_on_q) begin
            if (rate_q != '0) begin
                if (match_found) begin
                    tgt      = match_idx;
                    write_on = 1'b1;
                end else if (free_found) begin
                    tgt      = free_idx;
                    write_on = 1'b1;
                end
`ifdef VOICE_STEAL_EN
                else if (old_found) begin
                    tgt      = old_idx;
                    write_on = 1'b1;
                    do_steal = 1'b1;
                end
`endif
            end
        end else if (match_found) begin
            tgt       = match_idx;
            write_off = 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state         <= IDLE;
            idx           <= '0;
            is_on_q       <= 1'b0;
            rate_q        <= '0;
            on_tbl        <= '0;
            match_found   <= 1'b0;
            free_found    <= 1'b0;
            old_found     <= 1'b0;
            match_idx     <= '0;
            free_idx      <= '0;
            old_idx       <= '0;
            old_age       <= '0;
            cfg_valid_out <= 1'b0;
            cfg_voice_out <= '0;
            cfg_on_out    <= 1'b0;
            cfg_rate_out  <= '0;
            steal_out     <= 1'b0;
            drop_out      <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                rate_tbl[i] <= '0;
                age_tbl[i]  <= '0;
            end
        end else begin
            cfg_valid_out <= 1'b0;
            steal_out     <= 1'b0;
            drop_out      <= 1'b0;
            case (state)
                IDLE: begin
                    if (event_valid_in) begin
                        is_on_q     <= event_is_on_in;
                        rate_q      <= event_rate_in;
                        idx         <= '0;
                        match_found <= 1'b0;
                        free_found  <= 1'b0;
                        old_found   <= 1'b0;
                        old_age     <= '0;
                        state       <= SCAN;
                    end
                end
                SCAN: begin
                    if (on_tbl[idx]) begin
                        if (!match_found && rate_tbl[idx] == rate_q) begin
                            match_found <= 1'b1;
                            match_idx   <= idx;
                        end
                        // strict compare keeps the lowest index on equal ages
                        if (!old_found || age_tbl[idx] > old_age) begin
                            old_found <= 1'b1;
                            old_idx   <= idx;
                            old_age   <= age_tbl[idx];
                        end
                    end else if (!free_found) begin
                        free_found <= 1'b1;
                        free_idx   <= idx;
                    end
                    if (idx == LAST_IDX) state <= COMMIT;
                    else                 idx   <= idx + IDX_W'(1);
                end
                COMMIT: begin
                    state <= IDLE;
                    if (write_on || write_off) begin
                        cfg_valid_out <= 1'b1;
                        cfg_voice_out <= tgt;
                        cfg_on_out    <= write_on;
                        cfg_rate_out  <= write_on ? rate_q : '0;
                        steal_out     <= do_steal;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (IDX_W'(i) == tgt) begin
                                on_tbl[i]   <= write_on;
                                rate_tbl[i] <= write_on ? rate_q : '0;
                                age_tbl[i]  <= '0;
                            end else if (write_on && on_tbl[i] && age_tbl[i] != '1) begin
                                age_tbl[i] <= age_tbl[i] + AGE_WIDTH'(1);
                            end
                        end
                    end else begin
                        drop_out <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// Scoreboard bench for voice_scheduler: stimulus pushes expected commits, a negedge monitor pops and compares.
module tb_voice_scheduler;
    localparam int NV = 4;
    localparam int RW = 24;
    localparam int AW = 16;
`ifdef VOICE_STEAL_EN
    localparam bit STEAL = 1'b1;
`else
    localparam bit STEAL = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b0;
    logic          event_valid_in = 1'b0;
    logic          event_ready_out;
    logic          event_is_on_in = 1'b0;
    logic [RW-1:0] event_rate_in = '0;
    logic          cfg_valid_out;
    logic [1:0]    cfg_voice_out;
    logic          cfg_on_out;
    logic [RW-1:0] cfg_rate_out;
    logic [NV-1:0] voice_on_out;
    logic          steal_out;
    logic          drop_out;

    voice_scheduler #(.NUM_VOICES(NV), .RATE_WIDTH(RW), .AGE_WIDTH(AW)) dut (
        .clk_in(clk_in), .rst_in(rst_in),
        .event_valid_in(event_valid_in), .event_ready_out(event_ready_out),
        .event_is_on_in(event_is_on_in), .event_rate_in(event_rate_in),
        .cfg_valid_out(cfg_valid_out), .cfg_voice_out(cfg_voice_out),
        .cfg_on_out(cfg_on_out), .cfg_rate_out(cfg_rate_out),
        .voice_on_out(voice_on_out), .steal_out(steal_out), .drop_out(drop_out)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        bit drop;
        int voice;
        bit on;
        int rate;
        bit steal;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   total = 0;
    int   passed = 0;
    bit   ok;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (cfg_valid_out || drop_out) begin
            total++;
            if (q.size() == 0) begin
                $display("FAIL unexpected_pulse at cyc %0d: cfg_valid=%0b drop=%0b, required no pulse",
                         cyc, cfg_valid_out, drop_out);
            end else begin
                e = q.pop_front();
                ok = (cfg_valid_out == !e.drop) && (drop_out == e.drop) &&
                     (steal_out == e.steal) && (cyc == e.due);
                if (!e.drop)
                    ok = ok && (int'(cfg_voice_out) == e.voice) && (cfg_on_out == e.on) &&
                         (int'(cfg_rate_out) == e.rate);
                if (ok) passed++;
                else $display("FAIL event got cyc=%0d valid=%0b drop=%0b steal=%0b voice=%0d on=%0b rate=%0d required cyc=%0d drop=%0b steal=%0b voice=%0d on=%0b rate=%0d",
                              cyc, cfg_valid_out, drop_out, steal_out, cfg_voice_out, cfg_on_out, cfg_rate_out,
                              e.due, e.drop, e.steal, e.voice, e.on, e.rate);
            end
        end else if (q.size() != 0 && cyc > q[0].due) begin
            total++;
            $display("FAIL missing_pulse at cyc %0d, required at cyc %0d", cyc, q[0].due);
            void'(q.pop_front());
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s got %0d required %0d", name, got, exp);
    endtask

    // Waits for ready, records the expectation and completes the handshake on the next posedge.
    task automatic send(input bit on, input int rate, input bit push, input bit drop,
                        input int voice, input bit steal, output int waited);
        exp_t x;
        @(negedge clk_in);
        event_valid_in = 1'b1;
        event_is_on_in = on;
        event_rate_in  = RW'(rate);
        waited = 0;
        while (!event_ready_out && waited < 100) begin
            @(negedge clk_in);
            waited++;
        end
        if (waited >= 100) begin
            $display("FAIL ready_timeout waiting for ready");
            total++;
            $display("%0d/%0d checks passed", passed, total);
            $fatal(1, "ready never returned");
        end
        if (push) begin
            x.drop = drop; x.voice = voice; x.on = on; x.rate = on ? rate : 0;
            x.steal = steal; x.due = cyc + NV + 2;
            q.push_back(x);
        end
        @(posedge clk_in);
    endtask

    task automatic release_valid();
        @(negedge clk_in);
        event_valid_in = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        @(negedge clk_in);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        event_valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_in);
            chk("ready_in_reset", int'(event_ready_out), 0);
        end
        rst_in = 1'b1;
        event_valid_in = 1'b0;
        @(negedge clk_in);
        chk("ready_after_reset", int'(event_ready_out), 1);
        chk("voice_on_after_reset", int'(voice_on_out), 0);
    endtask

    int w;

    initial begin
        // 1. reset
        do_reset();

        // 2. allocation
        send(1, 100, 1, 0, 0, 0, w);
        send(1, 200, 1, 0, 1, 0, w);
        send(1, 300, 1, 0, 2, 0, w);
        release_valid();
        drain();
        chk("voice_on_alloc", int'(voice_on_out), 4'b0111);
        // voice 0 carries age 2 after two later allocations, so it is the steal victim
        send(1, 400, 1, 0, 3, 0, w);
        send(1, 500, 1, !STEAL, 0, STEAL, w);
        release_valid();
        drain();

        // 3. note-off
        do_reset();
        send(1, 100, 1, 0, 0, 0, w);
        send(1, 200, 1, 0, 1, 0, w);
        send(1, 300, 1, 0, 2, 0, w);
        send(0, 200, 1, 0, 1, 0, w);
        release_valid();
        drain();
        chk("voice_on_off", int'(voice_on_out), 4'b0101);
        send(0, 999, 1, 1, 0, 0, w);
        send(1, 250, 1, 0, 1, 0, w);
        release_valid();
        drain();
        chk("voice_on_refill", int'(voice_on_out), 4'b0111);

        // 4. steal
        do_reset();
        send(1, 10, 1, 0, 0, 0, w);
        send(1, 20, 1, 0, 1, 0, w);
        send(1, 30, 1, 0, 2, 0, w);
        send(1, 40, 1, 0, 3, 0, w);
        send(1, 50, 1, !STEAL, 0, STEAL, w);
        send(1, 60, 1, !STEAL, 1, STEAL, w);
        // with stealing, voice 1 now holds 60; without it, 20 is still resident
        send(0, 20, 1, STEAL, 1, 0, w);
        release_valid();
        drain();
        chk("voice_on_steal", int'(voice_on_out), STEAL ? 4'b1111 : 4'b1101);

        // 5. retrigger
        do_reset();
        send(1, 10, 1, 0, 0, 0, w);
        send(1, 10, 1, 0, 0, 0, w);
        release_valid();
        drain();
        chk("voice_on_retrig", int'(voice_on_out), 4'b0001);
        send(1, 20, 1, 0, 1, 0, w);
        send(1, 10, 1, 0, 0, 0, w);
        send(0, 10, 1, 0, 0, 0, w);
        release_valid();
        drain();
        chk("voice_on_retrig_off", int'(voice_on_out), 4'b0010);

        // 6. back-to-back, rate 0, reset mid-scan
        do_reset();
        send(1, 7, 1, 0, 0, 0, w);
        send(1, 8, 1, 0, 1, 0, w);
        chk("ready_low_cycles_2", w, NV + 1);
        send(1, 9, 1, 0, 2, 0, w);
        chk("ready_low_cycles_3", w, NV + 1);
        send(1, 0, 1, 1, 0, 0, w);
        send(0, 8, 1, 0, 1, 0, w);
        release_valid();
        drain();
        chk("voice_on_b2b", int'(voice_on_out), 4'b0101);
        send(1, 11, 0, 0, 0, 0, w);
        @(negedge clk_in);
        event_valid_in = 1'b0;
        rst_in = 1'b0;
        @(negedge clk_in);
        rst_in = 1'b1;
        repeat (10) @(negedge clk_in);
        chk("voice_on_mid_scan_reset", int'(voice_on_out), 0);
        send(1, 12, 1, 0, 0, 0, w);
        release_valid();
        drain();
        chk("voice_on_recover", int'(voice_on_out), 4'b0001);
        chk("queue_empty", q.size(), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
